fault_map_collector: RTL

- Sits directly downstream of the per-column comparator in the self-test datapath.
- Consumes the per-column mismatch vector for each applied test pattern and accumulates a sticky per-PE fault map (row x column) over one test session.
- At the end of the session it produces a per-column fault summary and a fault count, which the self-recovery control logic uses to remap faulty PEs.

---
 rtl/fault_map_collector.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fault_map_collector.sv
// rtl/fault_map_collector.sv - sticky per-PE fault map collector for the systolic self-test datapath
//
// Purpose: merges each per-column mismatch vector into a row x column fault map
// over one test session, then publishes the fault count and a done pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      session control (start honoured in IDLE, abort in COLLECT)
//   num_patterns      number of valid results in the session, latched on start
//   result_valid      row_idx / compared_results valid this cycle
//   row_idx           PE row of the current results
//   compared_results  bit c set = column c mismatched
//   fault_map_flat    bit r*SYSTOLIC_SIZE+c = PE(r,c) faulty
//   fault_col_vec     per-column OR of the map
//   fault_count       registered popcount of the map
//   busy, done        status; done is a one-cycle pulse at session end
module fault_map_collector #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PATTERN_CNT_WIDTH = 8,
  parameter int ROW_IDX_WIDTH     = $clog2(SYSTOLIC_SIZE),
  parameter int FAULT_CNT_WIDTH   = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE)+1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [PATTERN_CNT_WIDTH-1:0]           num_patterns,
  input  logic                                   result_valid,
  input  logic [ROW_IDX_WIDTH-1:0]               row_idx,
  input  logic [SYSTOLIC_SIZE-1:0]               compared_results,
  output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] fault_map_flat,
  output logic [SYSTOLIC_SIZE-1:0]               fault_col_vec,
  output logic [FAULT_CNT_WIDTH-1:0]             fault_count,
  output logic                                   busy,
  output logic                                   done
);

  localparam int MAP_BITS = SYSTOLIC_SIZE * SYSTOLIC_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUMMARY, S_DONE} state_t;

  state_t                       state;
  logic [PATTERN_CNT_WIDTH-1:0] pattern_cnt;
  logic [PATTERN_CNT_WIDTH-1:0] target;
  logic [PATTERN_CNT_WIDTH-1:0] cnt_inc;
  logic [MAP_BITS-1:0]          row_mask;
  logic [FAULT_CNT_WIDTH-1:0]   map_pop;
  logic                         row_ok;

  assign cnt_inc  = pattern_cnt + 1'b1;
  assign busy     = (state != S_IDLE);
  // Current mismatch vector positioned onto the selected row of the map.
  assign row_mask = MAP_BITS'(compared_results) << (int'(row_idx) * SYSTOLIC_SIZE);

  // A range check only exists when row_idx can encode rows past the array.
  generate
    if ((1 << ROW_IDX_WIDTH) > SYSTOLIC_SIZE) begin : g_range
      assign row_ok = (int'(row_idx) < SYSTOLIC_SIZE);
    end else begin : g_full
      assign row_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    fault_col_vec = '0;
    for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
      for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
        fault_col_vec[c] = fault_col_vec[c] | fault_map_flat[r*SYSTOLIC_SIZE + c];
      end
    end
  end

  always_comb begin
    map_pop = '0;
    for (int i = 0; i < MAP_BITS; i++) begin
      map_pop = map_pop + FAULT_CNT_WIDTH'(fault_map_flat[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      fault_map_flat <= '0;
      pattern_cnt    <= '0;
      target         <= '0;
      fault_count    <= '0;
      done           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            fault_map_flat <= '0;
            pattern_cnt    <= '0;
            target         <= num_patterns;
            state          <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // abort wins over a coincident result, which is dropped.
          if (abort) begin
            state <= S_IDLE;
          end else if (target == '0) begin
            state <= S_SUMMARY;
          end else if (result_valid) begin
            if (row_ok) begin
              fault_map_flat <= fault_map_flat | row_mask;
            end
            pattern_cnt <= cnt_inc;
            if (cnt_inc == target) begin
              state <= S_SUMMARY;
            end
          end
        end
        S_SUMMARY: begin
          fault_count <= map_pop;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
